// File: rtl/merge_tree_pkg.sv
// merge_tree_pkg: shared sizing helpers and key ordering for the merge tree
package merge_tree_pkg;
  localparam int MAX_LOG2_INPUTS = 5;
  localparam int KEY_MAX_W = 32;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int n_inputs(input int log2_inputs);
    return 1 << log2_inputs;
  endfunction
  function automatic int word_w(input int dw, input int log2_inputs);
    return dw + log2_inputs;
  endfunction
  function automatic logic pick_a(input logic [KEY_MAX_W-1:0] key_a, input logic [KEY_MAX_W-1:0] key_b, input logic desc);
    return desc ? key_a >= key_b : key_a <= key_b;
  endfunction
endpackage

// File: rtl/merge_tree_node.sv
// merge_node: one 2-input ordered merge stage holding a single output word
module merge_node
  import merge_tree_pkg::*;
#(
  parameter int W = 15,
  parameter int KEY_MSB = 11,
  parameter int KEY_LSB = 6,
  parameter int DESCENDING = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] a_data_i,
  input  logic         a_valid_i,
  input  logic         a_done_i,
  input  logic [W-1:0] b_data_i,
  input  logic         b_valid_i,
  input  logic         b_done_i,
  input  logic         read_i,
  output logic         a_read_o,
  output logic         b_read_o,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         done_o
);
  logic [W-1:0] data_q, data_d;
  logic valid_q, valid_d, rdy, a_first, take_a, take_b;
  // pick the next word; a lone side only goes once the other side can never supply a smaller key
  always_comb begin
    rdy = en_i & (!valid_q | read_i);
    a_first = pick_a(KEY_MAX_W'(a_data_i[KEY_MSB:KEY_LSB]), KEY_MAX_W'(b_data_i[KEY_MSB:KEY_LSB]), DESCENDING != 0);
    take_a = rdy & a_valid_i & (b_valid_i ? a_first : b_done_i);
    take_b = rdy & b_valid_i & (a_valid_i ? !a_first : a_done_i);
    valid_d = rdy ? take_a | take_b : valid_q;
    data_d = take_a ? a_data_i : take_b ? b_data_i : data_q;
  end
  // output register
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  assign a_read_o = take_a;
  assign b_read_o = take_b;
  assign data_o = data_q;
  assign valid_o = valid_q;
  assign done_o = a_done_i & b_done_i & !a_valid_i & !b_valid_i & !valid_q;
endmodule

// File: rtl/merge_tree_n.sv
// merge_tree_n: N-input key-ordered merge tree; MERGE_TREE_COUNT_EN adds the out_count delivery counter
module merge_tree_n
  import merge_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int KEY_MSB = 11,
  parameter int KEY_LSB = 6,
  parameter int LOG2_INPUTS = 3,
  parameter int DESCENDING = 0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     en,
  input  logic [(1<<LOG2_INPUTS)*DATA_WIDTH-1:0]   in_data,
  input  logic [(1<<LOG2_INPUTS)-1:0]              in_valid,
  input  logic [(1<<LOG2_INPUTS)-1:0]              in_done,
  output logic [(1<<LOG2_INPUTS)-1:0]              in_read,
  input  logic                                     out_read,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic [LOG2_INPUTS-1:0]                   out_index,
  output logic                                     out_valid,
  output logic                                     event_done
`ifdef MERGE_TREE_COUNT_EN
  ,
  output logic [15:0]                              out_count
`endif
);
  localparam int N = n_inputs(LOG2_INPUTS);
  localparam int LI = clog2(N);
  localparam int WW = word_w(DATA_WIDTH, LI);
  logic adv, root_read;
  assign adv = en & !reset;
  assign root_read = out_read & out_valid;
  for (genvar l = 0; l <= LOG2_INPUTS; l++) begin : g_lvl
    localparam int M = N >> l;
    logic [WW-1:0] dat [M];
    logic vld [M];
    logic dne [M];
    if (l == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_tag
        assign dat[i] = {LI'(i), in_data[i*DATA_WIDTH +: DATA_WIDTH]};
        assign vld[i] = in_valid[i];
        assign dne[i] = in_done[i];
        assign in_read[i] = g_lvl[1].g_nodes.rd_dn[i];
      end
    end else begin : g_nodes
      logic rd_dn [2*M];
      for (genvar j = 0; j < M; j++) begin : g_node
        logic up_rd;
        if (l == LOG2_INPUTS) begin : g_root
          assign up_rd = root_read;
        end else begin : g_mid
          assign up_rd = g_lvl[l+1].g_nodes.rd_dn[j];
        end
        merge_node #(
          .W(WW), .KEY_MSB(KEY_MSB), .KEY_LSB(KEY_LSB), .DESCENDING(DESCENDING)
        ) u_node (
          .clk(clk),
          .reset(reset),
          .en_i(adv),
          .a_data_i(g_lvl[l-1].dat[2*j]),
          .a_valid_i(g_lvl[l-1].vld[2*j]),
          .a_done_i(g_lvl[l-1].dne[2*j]),
          .b_data_i(g_lvl[l-1].dat[2*j+1]),
          .b_valid_i(g_lvl[l-1].vld[2*j+1]),
          .b_done_i(g_lvl[l-1].dne[2*j+1]),
          .read_i(up_rd),
          .a_read_o(rd_dn[2*j]),
          .b_read_o(rd_dn[2*j+1]),
          .data_o(dat[j]),
          .valid_o(vld[j]),
          .done_o(dne[j])
        );
      end
    end
  end
  assign out_data = g_lvl[LOG2_INPUTS].dat[0][DATA_WIDTH-1:0];
  assign out_index = g_lvl[LOG2_INPUTS].dat[0][WW-1:DATA_WIDTH];
  assign out_valid = g_lvl[LOG2_INPUTS].vld[0];
  assign event_done = g_lvl[LOG2_INPUTS].dne[0];
`ifdef MERGE_TREE_COUNT_EN
  logic done_q;
  logic [15:0] count_q, count_d;
  // count delivered words, restarting one cycle after each event completes
  always_comb count_d = (event_done & !done_q) ? 16'd0 : (root_read & adv & (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
  // counter and completion-edge registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      done_q <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q <= event_done;
    end
  end
  assign out_count = count_q;
`endif
endmodule

// File: tb/tb_merge_tree_n.sv
// tb_merge_tree_n: randomized and directed checks of merge_tree_n against a sorted-multiset model
module tb_merge_tree_n;
  localparam int DW = 12, NMAX = 32, BUDGET = 4000;
  typedef struct { logic [DW-1:0] d; int idx; int key; } exp_t;
  logic clk = 0, reset = 1, en = 1, out_read = 0;
  logic [NMAX*DW-1:0] in_data = '0;
  logic [NMAX-1:0] in_valid = '0, in_done = '0;
  logic [7:0] rd0, rd1;
  logic [1:0] rd2;
  logic [31:0] rd3, rd_m;
  logic [DW-1:0] od [4];
  logic [DW-1:0] od_m;
  logic [2:0] oi0, oi1;
  logic oi2;
  logic [4:0] oi3, oi_m;
  logic ov [4];
  logic ed [4];
  logic ov_m, ed_m;
  logic [15:0] cnt [4];
  int cur = 0, lg = 3, n = 8, stall_pct = 0, rd_pct = 100, en_lo = -1, en_hi = -1;
  int first_pop, first_out, n_cmp = 0, n_err = 0;
  bit desc = 0;
  int gate [NMAX];
  logic [DW-1:0] q [NMAX][$];
  exp_t ex [$];

  always #5 clk = ~clk;

  merge_tree_n #(.LOG2_INPUTS(3)) dut (
    .clk(clk), .reset(reset), .en(en && cur == 0), .in_data(in_data[8*DW-1:0]), .in_valid(in_valid[7:0]),
    .in_done(in_done[7:0]), .in_read(rd0), .out_read(out_read), .out_data(od[0]), .out_index(oi0),
    .out_valid(ov[0]), .event_done(ed[0])
`ifdef MERGE_TREE_COUNT_EN
    , .out_count(cnt[0])
`endif
  );
  merge_tree_n #(.LOG2_INPUTS(3), .DESCENDING(1)) dut_d (
    .clk(clk), .reset(reset), .en(en && cur == 1), .in_data(in_data[8*DW-1:0]), .in_valid(in_valid[7:0]),
    .in_done(in_done[7:0]), .in_read(rd1), .out_read(out_read), .out_data(od[1]), .out_index(oi1),
    .out_valid(ov[1]), .event_done(ed[1])
`ifdef MERGE_TREE_COUNT_EN
    , .out_count(cnt[1])
`endif
  );
  merge_tree_n #(.LOG2_INPUTS(1)) dut_1 (
    .clk(clk), .reset(reset), .en(en && cur == 2), .in_data(in_data[2*DW-1:0]), .in_valid(in_valid[1:0]),
    .in_done(in_done[1:0]), .in_read(rd2), .out_read(out_read), .out_data(od[2]), .out_index(oi2),
    .out_valid(ov[2]), .event_done(ed[2])
`ifdef MERGE_TREE_COUNT_EN
    , .out_count(cnt[2])
`endif
  );
  merge_tree_n #(.LOG2_INPUTS(5)) dut_5 (
    .clk(clk), .reset(reset), .en(en && cur == 3), .in_data(in_data), .in_valid(in_valid),
    .in_done(in_done), .in_read(rd3), .out_read(out_read), .out_data(od[3]), .out_index(oi3),
    .out_valid(ov[3]), .event_done(ed[3])
`ifdef MERGE_TREE_COUNT_EN
    , .out_count(cnt[3])
`endif
  );

  always_comb begin
    rd_m = cur == 0 ? 32'(rd0) : cur == 1 ? 32'(rd1) : cur == 2 ? 32'(rd2) : rd3;
    oi_m = cur == 0 ? 5'(oi0) : cur == 1 ? 5'(oi1) : cur == 2 ? 5'(oi2) : oi3;
    od_m = od[cur];
    ov_m = ov[cur];
    ed_m = ed[cur];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit prec(exp_t a, exp_t b);
    return a.key != b.key ? (desc ? a.key > b.key : a.key < b.key) : a.idx < b.idx;
  endfunction

  // expected output = all words ordered by key, then source index, then arrival order
  task automatic push(input int i, input int key);
    exp_t w;
    int p;
    w.key = key;
    w.idx = i;
    w.d = {key[5:0], 6'(q[i].size() * 5 + i)};
    p = ex.size();
    for (int k = 0; k < ex.size(); k++)
      if (prec(w, ex[k])) begin p = k; break; end
    ex.insert(p, w);
    q[i].push_back(w.d);
  endtask

  task automatic rand_streams(input int nw);
    int last [NMAX];
    int i, inc;
    for (int k = 0; k < NMAX; k++) last[k] = desc ? 63 - int'($urandom_range(0, 8)) : int'($urandom_range(0, 8));
    for (int k = 0; k < nw; k++) begin
      i = $urandom_range(0, n - 1);
      inc = $urandom_range(0, 4);
      last[i] = desc ? (last[i] > inc ? last[i] - inc : 0) : (last[i] + inc < 63 ? last[i] + inc : 63);
      push(i, last[i]);
    end
  endtask

  task automatic drive(input int cyc);
    en = !(cyc >= en_lo && cyc < en_hi);
    out_read = en && ($urandom_range(0, 99) < rd_pct);
    for (int i = 0; i < NMAX; i++) begin
      in_valid[i] = cyc >= gate[i] && q[i].size() > 0 && ($urandom_range(0, 99) >= stall_pct);
      in_data[i*DW +: DW] = q[i].size() > 0 ? q[i][0] : '0;
      in_done[i] = cyc >= gate[i] && q[i].size() == 0;
    end
  endtask

  task automatic setup(input int c);
    cur = c;
    lg = c == 2 ? 1 : c == 3 ? 5 : 3;
    n = 1 << lg;
    desc = c == 1;
    for (int i = 0; i < NMAX; i++) begin q[i].delete(); gate[i] = 0; end
    ex.delete();
    stall_pct = 0; rd_pct = 100; en_lo = -1; en_hi = -1;
    reset = 1;
    drive(0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic run(input int stop_at);
    int cyc = 0, pos = 0;
    logic pstall = 0;
    logic [DW-1:0] pd = '0;
    logic [4:0] pi = '0;
    logic [NMAX-1:0] pop;
    first_pop = -1;
    first_out = -1;
    drive(0);
    while (pos < ex.size() && cyc < stop_at) begin
      @(negedge clk);
      chk("rd_legal", rd_m & ~in_valid, 0);
      if (!en) chk("en_rd", rd_m, 0);
      if (pstall) begin
        chk("hold_vld", ov_m, 1);
        chk("hold_data", od_m, pd);
        chk("hold_idx", oi_m, pi);
      end
      if (rd_m != 0 && first_pop < 0) first_pop = cyc;
      if (ov_m && first_out < 0) first_out = cyc;
      if (ov_m && out_read && en) begin
        chk("word", od_m, ex[pos].d);
        chk("index", oi_m, ex[pos].idx);
        pos++;
      end
      pstall = ov_m && !(out_read && en);
      pd = od_m;
      pi = oi_m;
      pop = rd_m;
      @(posedge clk);
      #1;
      for (int i = 0; i < NMAX; i++) if (pop[i] && q[i].size() > 0) void'(q[i].pop_front());
      cyc++;
      drive(cyc);
    end
    if (stop_at == BUDGET) chk("all_words", pos, ex.size());
  endtask

  task automatic wait_done();
    int k = 0;
    while (!ed_m && k < 10) begin @(negedge clk); k++; end
    chk("event_done", ed_m, 1);
  endtask

  initial begin
    bit any;
    for (int i = 0; i < NMAX; i++) gate[i] = 1000;
    drive(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", ov_m, 0);
    chk("rst_data", od_m, 0);
    chk("rst_idx", oi_m, 0);
    chk("rst_rd", rd_m, 0);
    chk("rst_ed0", ed_m, 0);
    for (int i = 0; i < NMAX; i++) gate[i] = 0;
    drive(0);
    #1 chk("rst_ed1", ed_m, 1);
    @(posedge clk);
    #1;
    setup(0);
    push(0, 1); push(0, 5); push(0, 9); push(7, 2); push(7, 6);
    run(BUDGET);
    chk("latency3", first_out - first_pop, 3);
    wait_done();
    setup(0);
    push(0, 10); push(1, 3);
    gate[1] = 8;
    run(BUDGET);
    chk("strict_first_out", first_out, 11);
    wait_done();
    setup(0);
    push(2, 20); push(3, 20); push(2, 30); push(3, 25);
    run(BUDGET);
    setup(1);
    push(2, 20); push(3, 20); push(2, 7); push(3, 12);
    run(BUDGET);
    wait_done();
    setup(1);
    stall_pct = 25; rd_pct = 60;
    rand_streams(24);
    run(BUDGET);
    setup(0);
    stall_pct = 20; rd_pct = 50;
    rand_streams(16);
    run(BUDGET);
    @(negedge clk);
    chk("bp_ed", ed_m, 1);
`ifdef MERGE_TREE_COUNT_EN
    chk("count16", cnt[0], 16);
    @(negedge clk);
    chk("count_clr", cnt[0], 0);
`endif
    setup(0);
    rd_pct = 70; en_lo = 6; en_hi = 11;
    rand_streams(20);
    run(BUDGET);
    wait_done();
    setup(0);
    rd_pct = 0;
    rand_streams(12);
    run(6);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < NMAX; i++) q[i].delete();
    ex.delete();
    rd_pct = 100;
    drive(0);
    @(negedge clk);
    chk("rst_mid_vld", ov_m, 0);
    any = 0;
    repeat (10) begin @(negedge clk); any |= ov_m; end
    chk("no_stale", any, 0);
    chk("rst_mid_ed", ed_m, 1);
    @(posedge clk);
    #1;
    setup(2);
    rand_streams(20);
    run(BUDGET);
    chk("latency1", first_out - first_pop, 1);
    wait_done();
    setup(2);
    stall_pct = 30; rd_pct = 60;
    rand_streams(20);
    run(BUDGET);
    setup(3);
    rand_streams(60);
    run(BUDGET);
    chk("latency5", first_out - first_pop, 5);
    wait_done();
    setup(3);
    stall_pct = 30; rd_pct = 60;
    rand_streams(60);
    run(BUDGET);
    wait_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
